// File: rtl/voltage_readout_ctrl_pkg.sv
// voltage_pkg: shared states, divisors and widths for the voltage readout path
package voltage_pkg;
  typedef enum logic [2:0] {ACCUM, SCALE, D1000, D100, D10, DONE} state_t;
  localparam int MV_W = 13;
  localparam int FULL_SCALE_MV_DEF = 5000;
  localparam logic [MV_W-1:0] DIV_1000 = 13'd1000;
  localparam logic [MV_W-1:0] DIV_100 = 13'd100;
  localparam logic [MV_W-1:0] DIV_10 = 13'd10;
endpackage

// File: rtl/voltage_readout_ctrl_if.sv
// voltage_readout_ctrl_if: sample handshake in, millivolt/digit readout out
interface voltage_readout_ctrl_if #(parameter int ADC_W = 12);
  import voltage_pkg::*;
  logic sample_valid;
  logic [ADC_W-1:0] sample_data;
  logic sample_ready;
  logic [MV_W-1:0] mv_out;
  logic [3:0] digit_int;
  logic [3:0] digit_f1;
  logic [3:0] digit_f2;
  logic digit_valid;
  logic busy;
  logic [7:0] overrun_cnt;
  modport master(output sample_valid, sample_data,
                 input sample_ready, mv_out, digit_int, digit_f1, digit_f2, digit_valid, busy, overrun_cnt);
  modport slave(input sample_valid, sample_data,
                output sample_ready, mv_out, digit_int, digit_f1, digit_f2, digit_valid, busy, overrun_cnt);
endinterface

// File: rtl/voltage_readout_ctrl_digit_sub_div.sv
// digit_sub_div: one repeated-subtraction step of a decimal digit extraction
module digit_sub_div import voltage_pkg::*; (
  input  logic [MV_W-1:0] rem,
  input  logic [MV_W-1:0] divisor,
  output logic [MV_W-1:0] rem_nxt,
  output logic            inc,
  output logic            done
);
  assign inc = rem >= divisor;
  assign done = !inc;
  assign rem_nxt = inc ? rem - divisor : rem;
endmodule

// File: rtl/voltage_readout_ctrl.sv
// voltage_readout_ctrl: average ADC samples, scale to mV, extract BCD digits
module voltage_readout_ctrl import voltage_pkg::*; #(
  parameter int ADC_W = 12,
  parameter int FULL_SCALE_MV = FULL_SCALE_MV_DEF,
  parameter int AVG_LOG2 = 2
) (
  input logic clk,
  input logic rst,
  voltage_readout_ctrl_if.slave bus
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int P_W = ADC_W + MV_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2**AVG_LOG2 - 1);
  localparam logic [P_W-1:0] FS = P_W'(FULL_SCALE_MV);
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MV_W-1:0] rem_q, rem_d, mv_q, mv_d, mv_out_q, mv_out_d;
  logic [2:0][3:0] dig_q, dig_d, out_q, out_d;
  logic digit_valid_q, digit_valid_d;
  logic [7:0] overrun_q, overrun_d;
  logic ready, accept, drop, inc, sub_done;
  logic [P_W-1:0] prod;
  logic [MV_W-1:0] mv_calc, div, rem_nxt;
  logic [1:0] idx;
  assign ready = state_q == ACCUM;
  assign accept = bus.sample_valid && ready;
  assign drop = bus.sample_valid && !ready;
  assign prod = P_W'(acc_q[ACC_W-1:AVG_LOG2]) * FS;
  assign mv_calc = prod[P_W-1:ADC_W];
  assign div = state_q == D1000 ? DIV_1000 : state_q == D100 ? DIV_100 : DIV_10;
  assign idx = state_q == D1000 ? 2'd0 : state_q == D100 ? 2'd1 : 2'd2;
  digit_sub_div u_sub (.rem(rem_q), .divisor(div), .rem_nxt(rem_nxt), .inc(inc), .done(sub_done));
  assign bus.sample_ready = ready;
  assign bus.busy = !ready;
  assign bus.mv_out = mv_out_q;
  assign bus.digit_int = out_q[0];
  assign bus.digit_f1 = out_q[1];
  assign bus.digit_f2 = out_q[2];
  assign bus.digit_valid = digit_valid_q;
  assign bus.overrun_cnt = overrun_q;
  // sequencing: accumulate, scale, peel digits, then publish on entry to DONE
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    mv_d = mv_q;
    dig_d = dig_q;
    mv_out_d = mv_out_q;
    out_d = out_q;
    digit_valid_d = 1'b0;
    overrun_d = (drop && overrun_q != 8'hFF) ? overrun_q + 8'd1 : overrun_q;
    case (state_q)
      ACCUM: if (accept) begin
        acc_d = acc_q + ACC_W'(bus.sample_data);
        cnt_d = cnt_q + CNT_W'(1);
        state_d = cnt_q == CNT_LAST ? SCALE : ACCUM;
      end
      SCALE: begin
        mv_d = mv_calc;
        rem_d = mv_calc;
        dig_d = '0;
        acc_d = '0;
        cnt_d = '0;
        state_d = D1000;
      end
      D1000, D100, D10: begin
        rem_d = rem_nxt;
        if (inc) dig_d[idx] = dig_q[idx] + 4'd1;
        if (sub_done) begin
          state_d = state_q == D1000 ? D100 : state_q == D100 ? D10 : DONE;
          if (state_q == D10) begin
            mv_out_d = mv_q;
            out_d = dig_q;
            digit_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      rem_q <= '0;
      mv_q <= '0;
      dig_q <= '0;
      mv_out_q <= '0;
      out_q <= '0;
      digit_valid_q <= 1'b0;
      overrun_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      mv_q <= mv_d;
      dig_q <= dig_d;
      mv_out_q <= mv_out_d;
      out_q <= out_d;
      digit_valid_q <= digit_valid_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_voltage_readout_ctrl.sv
// tb_voltage_readout_ctrl: randomized self-checking bench against an arithmetic reference
module tb_voltage_readout_ctrl;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  voltage_readout_ctrl_if #(.ADC_W(12)) if0 ();
  voltage_readout_ctrl_if #(.ADC_W(12)) if2 ();
  voltage_readout_ctrl #(.ADC_W(12), .FULL_SCALE_MV(5000), .AVG_LOG2(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  voltage_readout_ctrl #(.ADC_W(12), .FULL_SCALE_MV(5000), .AVG_LOG2(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  function automatic int ref_mv(int avg);
    return (avg * 5000) / 4096;
  endfunction
  function automatic int ref_lat(int mv);
    return 2 + (mv / 1000 + 1) + ((mv / 100) % 10 + 1) + ((mv / 10) % 10 + 1);
  endfunction

  task automatic convert0(input int code, output int lat);
    int g = 0;
    while (!if0.sample_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if0.sample_valid = 1;
    if0.sample_data = 12'(code);
    @(negedge clk);
    if0.sample_valid = 0;
    lat = 1;
    while (!if0.digit_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    if0.sample_valid = 0; if0.sample_data = 0;
    if2.sample_valid = 0; if2.sample_data = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (if0.mv_out !== 0 || if0.digit_int !== 0 || if0.digit_f1 !== 0 || if0.digit_f2 !== 0) begin
      failures++;
      $display("FAIL reset_outputs mv=%0d digits=%0d%0d%0d expected 0", if0.mv_out, if0.digit_int, if0.digit_f1, if0.digit_f2);
    end
    checks++;
    if (if0.digit_valid !== 0 || if0.busy !== 0 || if0.overrun_cnt !== 0 || if0.sample_ready !== 1) begin
      failures++;
      $display("FAIL reset_ctrl dv=%b busy=%b ovr=%0d ready=%b expected 0,0,0,1", if0.digit_valid, if0.busy, if0.overrun_cnt, if0.sample_ready);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int codes[12];
    int lat, mv;
    codes[0] = 2048; codes[1] = 4095; codes[2] = 0; codes[3] = 819;
    for (int i = 4; i < 12; i++) codes[i] = int'($urandom_range(0, 4095));
    for (int i = 0; i < 12; i++) begin
      mv = ref_mv(codes[i]);
      convert0(codes[i], lat);
      checks++;
      if (lat !== ref_lat(mv)) begin
        failures++;
        $display("FAIL single_latency code=%0d got=%0d expected=%0d", codes[i], lat, ref_lat(mv));
      end
      checks++;
      if (if0.mv_out !== 13'(mv) || if0.digit_int !== 4'(mv / 1000) || if0.digit_f1 !== 4'((mv / 100) % 10) || if0.digit_f2 !== 4'((mv / 10) % 10)) begin
        failures++;
        $display("FAIL single_value code=%0d got mv=%0d %0d.%0d%0d expected mv=%0d %0d.%0d%0d", codes[i], if0.mv_out,
                 if0.digit_int, if0.digit_f1, if0.digit_f2, mv, mv / 1000, (mv / 100) % 10, (mv / 10) % 10);
      end
      @(negedge clk);
      checks++;
      if (if0.digit_valid !== 0 || if0.mv_out !== 13'(mv)) begin
        failures++;
        $display("FAIL single_pulse code=%0d dv=%b mv=%0d expected dv=0 mv=%0d", codes[i], if0.digit_valid, if0.mv_out, mv);
      end
    end
  endtask

  task automatic test_average();
    int s[4];
    int avg, mv, lat, bad;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 4; j++) s[j] = (r == 0) ? 1000 + 2 * j : int'($urandom_range(0, 4095));
      avg = (s[0] + s[1] + s[2] + s[3]) / 4;
      mv = ref_mv(avg);
      for (int j = 0; j < 4; j++) begin
        if2.sample_valid = 1;
        if2.sample_data = 12'(s[j]);
        @(negedge clk);
      end
      if2.sample_valid = 0;
      lat = 1; bad = 0;
      while (lat < 100) begin
        if (if2.sample_ready !== 0 || if2.busy !== 1) bad++;
        if (if2.digit_valid) break;
        @(negedge clk);
        lat++;
      end
      checks++;
      if (bad != 0 || lat !== ref_lat(mv)) begin
        failures++;
        $display("FAIL avg_timing set=%0d ready_violations=%0d latency=%0d expected 0 and %0d", r, bad, lat, ref_lat(mv));
      end
      checks++;
      if (if2.mv_out !== 13'(mv) || if2.digit_int !== 4'(mv / 1000) || if2.digit_f1 !== 4'((mv / 100) % 10) || if2.digit_f2 !== 4'((mv / 10) % 10)) begin
        failures++;
        $display("FAIL avg_value set=%0d got mv=%0d %0d.%0d%0d expected mv=%0d %0d.%0d%0d", r, if2.mv_out,
                 if2.digit_int, if2.digit_f1, if2.digit_f2, mv, mv / 1000, (mv / 100) % 10, (mv / 10) % 10);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    int cyc = 0, last = 0, n = 0, exp_ovr, g = 0;
    if0.sample_valid = 1;
    if0.sample_data = 12'd4095;
    while (n < 12 && cyc < 1000) begin
      if (if0.sample_ready) begin
        n++;
        exp_ovr = 27 * (n - 1) > 255 ? 255 : 27 * (n - 1);
        checks++;
        if (if0.overrun_cnt !== 8'(exp_ovr)) begin
          failures++;
          $display("FAIL overrun_count accept=%0d got=%0d expected=%0d", n, if0.overrun_cnt, exp_ovr);
        end
        if (n > 1) begin
          checks++;
          if (cyc - last !== 28) begin
            failures++;
            $display("FAIL overrun_spacing accept=%0d got=%0d expected=28", n, cyc - last);
          end
        end
        last = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    if0.sample_valid = 0;
    checks++;
    if (n !== 12) begin
      failures++;
      $display("FAIL overrun_accepts got=%0d expected=12", n);
    end
    while (!if0.sample_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (if0.overrun_cnt !== 8'd255 || if0.mv_out !== 13'd4998) begin
      failures++;
      $display("FAIL overrun_hold ovr=%0d mv=%0d expected 255 and 4998", if0.overrun_cnt, if0.mv_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat, seen = 0;
    if0.sample_valid = 1;
    if0.sample_data = 12'd2048;
    @(posedge clk);
    #1 if0.sample_valid = 0;
    repeat (6) @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if (if0.mv_out !== 0 || if0.digit_int !== 0 || if0.digit_f1 !== 0 || if0.digit_f2 !== 0 ||
        if0.busy !== 0 || if0.overrun_cnt !== 0 || if0.digit_valid !== 0) begin
      failures++;
      $display("FAIL midreset_clear mv=%0d digits=%0d%0d%0d busy=%b ovr=%0d dv=%b expected all 0", if0.mv_out,
               if0.digit_int, if0.digit_f1, if0.digit_f2, if0.busy, if0.overrun_cnt, if0.digit_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      if (if0.digit_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midreset_no_valid got=%0d pulses expected=0", seen);
    end
    convert0(2048, lat);
    checks++;
    if (lat !== 12 || if0.mv_out !== 13'd2500 || if0.digit_int !== 4'd2 || if0.digit_f1 !== 4'd5 || if0.digit_f2 !== 4'd0) begin
      failures++;
      $display("FAIL midreset_recover lat=%0d mv=%0d %0d.%0d%0d expected 12 2500 2.50", lat, if0.mv_out,
               if0.digit_int, if0.digit_f1, if0.digit_f2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_average();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voltage_readout_ctrl.md
Name: voltage_readout_ctrl

Overview:
- Sequences the ADC-to-display voltage path.
- Accepts raw 12-bit ADC samples over a valid/ready handshake and averages 2^AVG_LOG2 of them.
- Scales the average to millivolts, then extracts correct decimal digits (volts, tenths, hundredths) with a multi-cycle repeated-subtraction FSM.
- Presents the result to the seven-segment/display driver with a one-cycle valid strobe, and counts samples dropped while busy.

Parameters:
- ADC_W, 12, ADC sample width in bits.
- FULL_SCALE_MV, 5000, millivolts corresponding to code 2^ADC_W.
- AVG_LOG2, 2, log2 of the number of samples averaged per reading (0 = no averaging).

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  ADC sample present this cycle.
- sample_data  in  ADC_W  raw ADC code.
- sample_ready  out  1  block can accept a sample this cycle.
- mv_out  out  13  last computed voltage in mV (0..4998).
- digit_int  out  4  volts digit, BCD.
- digit_f1  out  4  tenths digit, BCD.
- digit_f2  out  4  hundredths digit, BCD.
- digit_valid  out  1  one-cycle pulse when new mv_out/digits are valid.
- busy  out  1  high in any state other than ACCUM.
- overrun_cnt  out  8  count of dropped samples, saturating.

Behaviour:
- Reset: asynchronous; all outputs 0, state ACCUM, accumulator and sample counter 0. Reset mid-conversion discards all partial work; no digit_valid is issued for it.
- Handshake: sample_ready = (state == ACCUM). A sample is accepted when sample_valid && sample_ready.
- Dropped samples: sample_valid && !sample_ready increments overrun_cnt, which saturates at 255 and clears only on rst.
- ACCUM state:
  - Accumulator width is ADC_W+AVG_LOG2 bits; it cannot overflow.
  - Each accepted sample adds to the accumulator and increments the sample counter.
  - On acceptance of the 2^AVG_LOG2-th sample, go to SCALE.
- SCALE (1 cycle):
  - avg = acc >> AVG_LOG2.
  - mv = (avg * FULL_SCALE_MV) >> ADC_W, using a full-width (ADC_W+13)-bit product and truncation, no rounding.
  - Load rem = mv, clear digits, clear accumulator and counter, go to D1000.
- D1000 / D100 / D10 states, with divisor 1000 / 100 / 10 respectively:
  - Each cycle, if rem >= divisor: rem -= divisor and digit += 1.
  - Otherwise advance to the next state; D10 advances to DONE.
  - Each state therefore lasts q+1 cycles, where q is that digit's value.
- Remainder: the final rem (units of mV) is discarded; it is truncated, not rounded.
- DONE (1 cycle):
  - Register mv_out and all three digits, and pulse digit_valid high for exactly this cycle.
  - Go to ACCUM.
  - Outputs hold until the next DONE.
- Latency: with AVG_LOG2=0, the first digit_valid cycle is 2+(q1+1)+(q2+1)+(q3+1) clocks after the accepting edge. Worst case (4998) is 27 cycles.
- Back-to-back samples: a sample presented in the DONE cycle is not accepted and counts as overrun. Acceptance resumes in the cycle after DONE.
- Digit range: digits never exceed 9; digit_int never exceeds 4 for the default parameters.

Decomposition:
- Package voltage_pkg holds:
  - state enum (ACCUM, SCALE, D1000, D100, D10, DONE);
  - divisor constants 1000/100/10;
  - FULL_SCALE_MV default;
  - the MV_W=13 width constant.
- Sub-module digit_sub_div (natural): one repeated-subtraction step unit.
  - Inputs: rem, divisor.
  - Outputs: next rem, increment flag, done flag.
  - Shared by the three digit states; the controller muxes in the divisor.

Test Plan:
- AVG_LOG2=0, sample 2048 -> mv_out=2500, digits 2,5,0; digit_valid 12 cycles after accept, high exactly 1 cycle.
- AVG_LOG2=0, sample 4095 -> mv_out=4998, digits 4,9,9; latency 27. Sample 0 -> 0,0,0, latency 5.
- AVG_LOG2=0, sample 819 -> mv_out=999, digits 0,9,9 (checks truncation and the zero integer digit).
- AVG_LOG2=2, samples 1000,1002,1004,1006 -> avg 1003 -> mv_out=1224, digits 1,2,2. sample_ready low from SCALE through DONE.
- sample_valid held high continuously with AVG_LOG2=0 and code 4095 -> one accept per 28 cycles, overrun_cnt +27 per reading, saturates at 255 and stays.
- Assert rst during D100 -> all outputs 0 immediately (asynchronous), no digit_valid. Next sample 2048 converts normally to 2,5,0.
